// File: rtl/program_loader.sv
// program_loader: streams a length-prefixed image into instruction memory while holding the CPU in reset.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing checksum word verified before release.
// Writes are registered (word accepted at t is written at t+1); stalls on in_valid never time out.
module program_loader #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 15,
  parameter int DEPTH     = 16384,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] pc,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_RUN, S_LEN, S_DATA, S_CHECK, S_FINISH, S_ERROR} state_t;
`else
  typedef enum logic [2:0] {S_RUN, S_LEN, S_DATA, S_FINISH, S_ERROR} state_t;
`endif

  state_t state, next_state;

  logic              accept;
  logic              len_bad;
  logic [ADDR_W:0]   remaining;
  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W-1:0] wr_addr;
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] csum;
`endif

  // State register; reset always lands in RUN so the CPU runs freely.
  always_ff @(posedge clk) begin
    if (reset) state <= S_RUN;
    else       state <= next_state;
  end

  // Next-state decode plus the combinational handshake and hold outputs.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    accept     = 1'b0;
    len_bad    = 1'b0;

    // A restart pulse owns the cycle: no word is taken while it is high.
`ifdef LOADER_CHECKSUM_EN
    in_ready = (state == S_LEN || state == S_DATA || state == S_CHECK) && !load_start;
`else
    in_ready = (state == S_LEN || state == S_DATA) && !load_start;
`endif
    accept  = in_valid && in_ready;
    len_bad = 64'(in_data) > 64'(DEPTH);

    if (load_start) begin
      next_state = S_LEN;
    end else begin
      case (state)
        S_RUN: next_state = S_RUN;
        S_LEN: begin
          if (accept) begin
            if (len_bad) next_state = S_ERROR;
            else if (in_data == '0)
`ifdef LOADER_CHECKSUM_EN
              next_state = S_CHECK;
`else
              next_state = S_FINISH;
`endif
            else next_state = S_DATA;
          end
        end
        S_DATA: begin
          if (accept && remaining == (ADDR_W+1)'(1))
`ifdef LOADER_CHECKSUM_EN
            next_state = S_CHECK;
`else
            next_state = S_FINISH;
`endif
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (accept) next_state = (in_data == csum) ? S_FINISH : S_ERROR;
        end
`endif
        S_FINISH: next_state = S_RUN;
        S_ERROR:  next_state = S_ERROR;
        default:  next_state = S_RUN;
      endcase
    end
  end

  // Memory address mux and status flags derived directly from the state.
  always_comb begin
    cpu_hold = (state != S_RUN);
    error    = (state == S_ERROR);
    mem_addr = (state == S_RUN) ? pc : wr_addr;
  end

  // Registered write port, counters and completion pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we       <= 1'b0;
      mem_wdata    <= '0;
      wr_addr      <= '0;
      next_addr    <= '0;
      remaining    <= '0;
      words_loaded <= '0;
      done         <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      // A restart issued during FINISH cancels the release, so no done pulse.
      done   <= (state == S_FINISH) && !load_start;
      if (load_start) begin
        next_addr    <= ADDR_W'(BASE_ADDR);
        remaining    <= '0;
        words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
        csum         <= '0;
`endif
      end else if (accept && state == S_LEN) begin
        // Truncation is harmless: oversized lengths go to ERROR instead of DATA.
        remaining <= (ADDR_W+1)'(in_data);
      end else if (accept && state == S_DATA) begin
        mem_we       <= 1'b1;
        mem_wdata    <= in_data;
        wr_addr      <= next_addr;
        next_addr    <= next_addr + ADDR_W'(1);
        remaining    <= remaining - (ADDR_W+1)'(1);
        words_loaded <= words_loaded + (ADDR_W+1)'(1);
`ifdef LOADER_CHECKSUM_EN
        csum         <= csum + in_data;
`endif
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: reset, normal load, bad length, stalls, abort/restart, reset mid-load.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Writes and done pulses are logged by monitors and compared against hand-computed expectations.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset, load_start, in_valid, in_ready;
  logic [15:0] in_data;
  logic [14:0] pc;
  logic        mem_we, cpu_hold, done, error;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] words_loaded;

`ifdef LOADER_CHECKSUM_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;
  logic [14:0] wa[$];
  logic [15:0] wd[$];
  int          done_cyc[$];

  program_loader dut (
    .clk(clk), .reset(reset), .load_start(load_start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .pc(pc), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
    .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Cycle stamp: number of rising edges seen so far.
  always @(posedge clk) cyc++;

  // Log every write and every done pulse.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
    end
    if (done === 1'b1) done_cyc.push_back(cyc);
  end

  task automatic clear_logs();
    wa.delete(); wd.delete(); done_cyc.delete();
  endtask

  // Pulse load_start for one edge; returns the cycle stamp of that edge.
  task automatic start_load(output int s);
    load_start = 1'b1;
    s = cyc + 1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  // Present one word and hold it until accepted (bounded).
  task automatic send(input logic [15:0] w);
    logic acc;
    in_valid = 1'b1;
    in_data  = w;
    for (int i = 0; i < 20; i++) begin
      #1;
      acc = in_ready;
      @(negedge clk);
      if (acc === 1'b1) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    vecs++; errs++;
    $display("FAIL send_timeout: word %h not accepted within 20 cycles", w);
  endtask

  // Wait for done, checking cpu_hold stays high until then and done's timing.
  task automatic wait_done(input int s, input int lat, input string nm);
    bit found = 0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) begin
        found = 1;
        break;
      end
      vecs++; if (cpu_hold !== 1'b1) begin errs++; $display("FAIL %s_hold_before_done: got %b want 1", nm, cpu_hold); end
      @(negedge clk);
    end
    vecs++;
    if (!found) begin
      errs++; $display("FAIL %s_done_timeout: done not seen, want at cycle %0d", nm, s + lat);
      return;
    end
    if (cyc !== s + lat) begin errs++; $display("FAIL %s_done_latency: got %0d want %0d", nm, cyc - s, lat); end
    vecs++; if (cpu_hold !== 1'b0) begin errs++; $display("FAIL %s_hold_at_done: got %b want 0", nm, cpu_hold); end
    @(negedge clk);
    vecs++; if (done !== 1'b0) begin errs++; $display("FAIL %s_done_width: got %b want 0", nm, done); end
  endtask

  task automatic test_reset();
    reset = 1'b1; pc = 15'h0123;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vecs++; if (mem_addr !== 15'h0123) begin errs++; $display("FAIL reset_mem_addr: got %h want 0123", mem_addr); end
    vecs++; if (cpu_hold !== 1'b0) begin errs++; $display("FAIL reset_cpu_hold: got %b want 0", cpu_hold); end
    vecs++; if (mem_we !== 1'b0) begin errs++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    vecs++; if (done !== 1'b0) begin errs++; $display("FAIL reset_done: got %b want 0", done); end
    vecs++; if (error !== 1'b0) begin errs++; $display("FAIL reset_error: got %b want 0", error); end
    vecs++; if (words_loaded !== 16'd0) begin errs++; $display("FAIL reset_words_loaded: got %0d want 0", words_loaded); end
    in_valid = 1'b1; #1;
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    in_valid = 1'b0;
    pc = 15'h4567; #1;
    vecs++; if (mem_addr !== 15'h4567) begin errs++; $display("FAIL run_pc_track: got %h want 4567", mem_addr); end
  endtask

  task automatic test_basic();
    int s;
    logic [15:0] d[3];
    logic [15:0] sum;
    d[0] = 16'hA001; d[1] = 16'hB002; d[2] = 16'hC003;
    sum = d[0] + d[1] + d[2];
    clear_logs();
    start_load(s);
    vecs++; if (cpu_hold !== 1'b1) begin errs++; $display("FAIL basic_hold_start: got %b want 1", cpu_hold); end
    send(16'd3);
    for (int i = 0; i < 3; i++) send(d[i]);
`ifdef LOADER_CHECKSUM_EN
    send(sum);
`endif
    wait_done(s, 5 + EXTRA, "basic");
    vecs++; if (wa.size() !== 3) begin errs++; $display("FAIL basic_write_count: got %0d want 3", wa.size()); end
    for (int i = 0; i < 3 && i < wa.size(); i++) begin
      vecs++; if (wa[i] !== 15'(i) || wd[i] !== d[i]) begin errs++; $display("FAIL basic_write%0d: got %h@%h want %h@%h", i, wd[i], wa[i], d[i], 15'(i)); end
    end
    vecs++; if (words_loaded !== 16'd3) begin errs++; $display("FAIL basic_words_loaded: got %0d want 3", words_loaded); end
    vecs++; if (done_cyc.size() !== 1) begin errs++; $display("FAIL basic_done_pulses: got %0d want 1", done_cyc.size()); end
    vecs++; if (mem_addr !== pc) begin errs++; $display("FAIL basic_pc_restored: got %h want %h", mem_addr, pc); end
  endtask

  task automatic test_bad_len();
    int s;
    clear_logs();
    start_load(s);
    send(16'd16385);
    vecs++; if (error !== 1'b1) begin errs++; $display("FAIL badlen_error: got %b want 1", error); end
    vecs++; if (cpu_hold !== 1'b1) begin errs++; $display("FAIL badlen_hold: got %b want 1", cpu_hold); end
    in_valid = 1'b1; in_data = 16'h1234; #1;
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL badlen_in_ready: got %b want 0", in_ready); end
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    vecs++; if (wa.size() !== 0) begin errs++; $display("FAIL badlen_no_writes: got %0d want 0", wa.size()); end
    vecs++; if (error !== 1'b1) begin errs++; $display("FAIL badlen_error_sticky: got %b want 1", error); end
    start_load(s);
    vecs++; if (error !== 1'b0) begin errs++; $display("FAIL badlen_error_clear: got %b want 0", error); end
    vecs++; if (cpu_hold !== 1'b1) begin errs++; $display("FAIL badlen_hold_after_restart: got %b want 1", cpu_hold); end
  endtask

  task automatic test_stall();
    int s;
    logic [15:0] d[3];
    logic [15:0] sum;
    d[0] = 16'h1111; d[1] = 16'h2222; d[2] = 16'h3333;
    sum = d[0] + d[1] + d[2];
    clear_logs();
    start_load(s);
    send(16'd3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      send(d[i]);
    end
`ifdef LOADER_CHECKSUM_EN
    send(sum);
`endif
    wait_done(s, 8 + EXTRA, "stall");
    vecs++; if (wa.size() !== 3) begin errs++; $display("FAIL stall_write_count: got %0d want 3", wa.size()); end
    for (int i = 0; i < 3 && i < wa.size(); i++) begin
      vecs++; if (wa[i] !== 15'(i) || wd[i] !== d[i]) begin errs++; $display("FAIL stall_write%0d: got %h@%h want %h@%h", i, wd[i], wa[i], d[i], 15'(i)); end
    end
  endtask

  task automatic test_abort();
    int s;
    clear_logs();
    start_load(s);
    send(16'd4);
    send(16'hD000);
    send(16'hD001);
    load_start = 1'b1; in_valid = 1'b1; in_data = 16'hD002; #1;
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL abort_in_ready: got %b want 0", in_ready); end
    @(negedge clk);
    s = cyc;
    load_start = 1'b0; in_valid = 1'b0;
    vecs++; if (words_loaded !== 16'd0) begin errs++; $display("FAIL abort_words_cleared: got %0d want 0", words_loaded); end
    vecs++; if (wa.size() !== 2) begin errs++; $display("FAIL abort_write_count: got %0d want 2", wa.size()); end
    for (int i = 0; i < 2 && i < wa.size(); i++) begin
      vecs++; if (wa[i] !== 15'(i)) begin errs++; $display("FAIL abort_addr%0d: got %h want %h", i, wa[i], 15'(i)); end
    end
    send(16'd1);
    send(16'h7777);
`ifdef LOADER_CHECKSUM_EN
    send(16'h7777);
`endif
    wait_done(s, 3 + EXTRA, "restart");
    vecs++; if (wa.size() !== 3) begin errs++; $display("FAIL restart_write_count: got %0d want 3", wa.size()); end
    if (wa.size() == 3) begin
      vecs++; if (wa[2] !== 15'h0000 || wd[2] !== 16'h7777) begin errs++; $display("FAIL restart_write: got %h@%h want 7777@0000", wd[2], wa[2]); end
    end
    vecs++; if (words_loaded !== 16'd1) begin errs++; $display("FAIL restart_words_loaded: got %0d want 1", words_loaded); end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_bad_checksum();
    int s;
    clear_logs();
    start_load(s);
    send(16'd3);
    send(16'hA001); send(16'hB002); send(16'hC003);
    send(16'h0000);
    vecs++; if (error !== 1'b1) begin errs++; $display("FAIL csum_error: got %b want 1", error); end
    repeat (3) @(negedge clk);
    vecs++; if (cpu_hold !== 1'b1) begin errs++; $display("FAIL csum_hold: got %b want 1", cpu_hold); end
    vecs++; if (done_cyc.size() !== 0) begin errs++; $display("FAIL csum_no_done: got %0d pulses want 0", done_cyc.size()); end
    vecs++; if (wa.size() !== 3) begin errs++; $display("FAIL csum_data_written: got %0d want 3", wa.size()); end
  endtask
`endif

  task automatic test_reset_midload();
    int s;
    clear_logs();
    start_load(s);
    send(16'd2);
    send(16'hEEEE);
    vecs++; if (mem_we !== 1'b1) begin errs++; $display("FAIL midreset_pending_we: got %b want 1", mem_we); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vecs++; if (mem_we !== 1'b0) begin errs++; $display("FAIL midreset_mem_we: got %b want 0", mem_we); end
    vecs++; if (cpu_hold !== 1'b0) begin errs++; $display("FAIL midreset_hold: got %b want 0", cpu_hold); end
    vecs++; if (words_loaded !== 16'd0) begin errs++; $display("FAIL midreset_words: got %0d want 0", words_loaded); end
    repeat (2) @(negedge clk);
    vecs++; if (wa.size() !== 1) begin errs++; $display("FAIL midreset_write_count: got %0d want 1", wa.size()); end
  endtask

  initial begin
    reset = 1'b1; load_start = 1'b0; in_valid = 1'b0; in_data = '0; pc = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_bad_len();
    test_stall();
    test_abort();
`ifdef LOADER_CHECKSUM_EN
    test_bad_checksum();
`endif
    test_reset_midload();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
